// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a word-addressed data memory.
// Sub-word stores use a read-modify-write so the memory only needs whole-word writes.
module mem_access_unit #(
  parameter int unsigned MEM_WORDS = 8193
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_add,
  output logic [31:0] mem_wdata,
  output logic        mem_read_en,
  output logic        mem_write_en,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] word_q, word_d;

  logic        acc_err;
  logic [4:0]  lane_sh;
  logic [31:0] rd_shifted;
  logic [31:0] load_ext;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  always_comb begin
    acc_err = 1'b0;
    if (req_size == 2'b11) acc_err = 1'b1;
    if (req_size == 2'b01 && req_addr[0] != 1'b0) acc_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) acc_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= MEM_WORDS) acc_err = 1'b1;
  end

  // Lane selection is shared by load extraction and store merging.
  always_comb begin
    lane_sh    = (size_q == 2'b00) ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
    rd_shifted = mem_rdata >> lane_sh;
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   load_ext = {{16{signed_q & rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_ext = mem_rdata;
    endcase
    lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh;
    merged    = (word_q & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    size_d       = size_q;
    signed_d     = signed_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    word_d       = word_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_wdata    = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d   = req_addr;
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          err_d    = acc_err;
          if (acc_err)               state_d = RESP;
          else if (!req_we)          state_d = LOAD;
          else if (req_size == 2'b10) state_d = STORE;
          else                       state_d = RMW_RD;
        end
      end
      LOAD: begin
        mem_read_en = 1'b1;
        rdata_d     = load_ext;
        state_d     = RESP;
      end
      RMW_RD: begin
        mem_read_en = 1'b1;
        word_d      = mem_rdata;
        state_d     = STORE;
      end
      STORE: begin
        mem_write_en = 1'b1;
        mem_wdata    = (size_q == 2'b10) ? wdata_q : merged;
        state_d      = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      size_q   <= '0;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      word_q   <= word_d;
    end
  end

  assign mem_add    = {2'b00, addr_q[31:2]};
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // we_q is retained as part of the registered request; only the state encodes direction.
  logic unused_we;
  assign unused_we = we_q;

endmodule
